// File: rtl/xls_sum_tree_pkg.sv
// Shared helpers for the pipelined N-operand sum tree: tree depth, per-level
// entry counts and packed-vector offsets. Feature macro: XLS_SUM_TREE_SAT_EN.
package xls_sum_tree_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 32'sd0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                r = i + 32'sd1;
            end
        end
        return r;
    endfunction

    // Level 0 is the operand vector itself; each later level halves, rounding up.
    function automatic int level_entries(input int n, input int j);
        int e;
        e = n;
        for (int i = 0; i < j; i++) begin
            e = (e + 32'sd1) / 32'sd2;
        end
        return e;
    endfunction

    // Entry index where level j starts when all levels are packed back to back.
    function automatic int entry_offset(input int n, input int j);
        int off;
        off = 32'sd0;
        for (int i = 0; i < j; i++) begin
            off = off + level_entries(n, i);
        end
        return off;
    endfunction

    function automatic int tree_levels(input int n);
        return clog2(n);
    endfunction

    function automatic int tree_stages(input int n);
        return clog2(n) + 32'sd1;
    endfunction

endpackage

// File: rtl/xls_sum_tree_level.sv
// One registered adder-tree level: adjacent pairs summed, odd last entry passed
// through. With XLS_SUM_TREE_SAT_EN each entry also carries an overflow flag.
module xls_sum_tree_level
    import xls_sum_tree_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_IN  = 3
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        in_valid,
    input  logic [N_IN*WIDTH-1:0]                       in_data,
`ifdef XLS_SUM_TREE_SAT_EN
    input  logic [N_IN-1:0]                             in_ovf,
    output logic [level_entries(N_IN, 1)-1:0]           out_ovf,
`endif
    input  logic                                        adv_next,
    output logic                                        load,
    output logic                                        out_valid,
    output logic [level_entries(N_IN, 1)*WIDTH-1:0]     out_data
);

    localparam int N_OUT = level_entries(N_IN, 1);

    logic [N_OUT*WIDTH-1:0] data_next_s;
    logic [N_OUT*WIDTH-1:0] data_r;
    logic                   valid_r;
`ifdef XLS_SUM_TREE_SAT_EN
    logic [N_OUT-1:0]       ovf_next_s;
    logic [N_OUT-1:0]       ovf_r;
`endif

    for (genvar i = 0; i < N_OUT; i++) begin : g_ent
        if (2 * i + 1 < N_IN) begin : g_pair
`ifdef XLS_SUM_TREE_SAT_EN
            logic [WIDTH:0] sum_s;
            assign sum_s = {1'b0, in_data[2*i*WIDTH +: WIDTH]}
                         + {1'b0, in_data[(2*i+1)*WIDTH +: WIDTH]};
            assign ovf_next_s[i] = sum_s[WIDTH] | in_ovf[2*i] | in_ovf[2*i+1];
            // Saturating early keeps every downstream level consistent with the flag.
            assign data_next_s[i*WIDTH +: WIDTH] = ovf_next_s[i] ? {WIDTH{1'b1}}
                                                                 : sum_s[WIDTH-1:0];
`else
            assign data_next_s[i*WIDTH +: WIDTH] = in_data[2*i*WIDTH +: WIDTH]
                                                 + in_data[(2*i+1)*WIDTH +: WIDTH];
`endif
        end else begin : g_pass
            assign data_next_s[i*WIDTH +: WIDTH] = in_data[2*i*WIDTH +: WIDTH];
`ifdef XLS_SUM_TREE_SAT_EN
            assign ovf_next_s[i] = in_ovf[2*i];
`endif
        end
    end

    // An empty stage always loads, so bubbles collapse under a downstream stall.
    assign load = !valid_r || adv_next;

    // Stage register; data only captured for a real entry so held values stay quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= '0;
`ifdef XLS_SUM_TREE_SAT_EN
            ovf_r   <= '0;
`endif
        end else if (load) begin
            valid_r <= in_valid;
            if (in_valid) begin
                data_r <= data_next_s;
`ifdef XLS_SUM_TREE_SAT_EN
                ovf_r  <= ovf_next_s;
`endif
            end
        end
    end

    assign out_valid = valid_r;
    assign out_data  = data_r;
`ifdef XLS_SUM_TREE_SAT_EN
    assign out_ovf   = ovf_r;
`endif

endmodule

// File: rtl/xls_sum_tree_pipe.sv
// Pipelined NUM_IN-operand adder: input register plus one register per tree
// level, valid/ready handshake. Optional saturation via XLS_SUM_TREE_SAT_EN.
module xls_sum_tree_pipe
    import xls_sum_tree_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_sum
);

    localparam int LEVELS   = tree_levels(NUM_IN);
    localparam int S        = tree_stages(NUM_IN);
    localparam int TOTAL_E  = entry_offset(NUM_IN, S);
    localparam int LAST_OFF = entry_offset(NUM_IN, LEVELS);

    // All stage data packed level after level; each level owns its own slice.
    logic [TOTAL_E*WIDTH-1:0] data_s;
    logic [S-1:0]             vld_s;
    logic [S:1]               adv_s;
`ifdef XLS_SUM_TREE_SAT_EN
    logic [TOTAL_E-1:0]       ovf_s;
`endif

    logic                     v0_r;
    logic [NUM_IN*WIDTH-1:0]  d0_r;
    logic                     load0_s;

    assign adv_s[S] = out_ready;
    assign load0_s  = !v0_r || adv_s[1];
    assign in_ready = load0_s;

    // Input operand register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_r <= 1'b0;
            d0_r <= '0;
        end else if (load0_s) begin
            v0_r <= in_valid;
            if (in_valid) begin
                d0_r <= in_data;
            end
        end
    end

    assign vld_s[0]                     = v0_r;
    assign data_s[NUM_IN*WIDTH-1:0]     = d0_r;
`ifdef XLS_SUM_TREE_SAT_EN
    assign ovf_s[NUM_IN-1:0]            = '0;
`endif

    for (genvar j = 1; j <= LEVELS; j++) begin : g_lvl
        localparam int NI    = level_entries(NUM_IN, j - 1);
        localparam int NO    = level_entries(NUM_IN, j);
        localparam int OFF_I = entry_offset(NUM_IN, j - 1);
        localparam int OFF_O = entry_offset(NUM_IN, j);

        xls_sum_tree_level #(
            .WIDTH (WIDTH),
            .N_IN  (NI)
        ) u_level (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (vld_s[j-1]),
            .in_data   (data_s[OFF_I*WIDTH +: NI*WIDTH]),
`ifdef XLS_SUM_TREE_SAT_EN
            .in_ovf    (ovf_s[OFF_I +: NI]),
            .out_ovf   (ovf_s[OFF_O +: NO]),
`endif
            .adv_next  (adv_s[j+1]),
            .load      (adv_s[j]),
            .out_valid (vld_s[j]),
            .out_data  (data_s[OFF_O*WIDTH +: NO*WIDTH])
        );
    end

    assign out_valid = vld_s[S-1];
    assign out_sum   = data_s[LAST_OFF*WIDTH +: WIDTH];

endmodule

// File: tb/tb_xls_sum_tree_pipe.sv
// Directed and table-driven bench for xls_sum_tree_pipe: default build plus
// NUM_IN=5/WIDTH=8 and NUM_IN=2/WIDTH=16 instances.
module tb_xls_sum_tree_pipe;

`ifdef XLS_SUM_TREE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [95:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_sum;

    logic        v5 = 1'b0, r5, ov5, or5 = 1'b1;
    logic [39:0] d5 = '0;
    logic [7:0]  s5;

    logic        v2 = 1'b0, r2, ov2, or2 = 1'b1;
    logic [31:0] d2 = '0;
    logic [15:0] s2;

    int errors = 0;
    int checks = 0;
    int got_cnt = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    xls_sum_tree_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
    );

    xls_sum_tree_pipe #(.WIDTH(8), .NUM_IN(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_ready(r5),
        .in_data(d5), .out_valid(ov5), .out_ready(or5), .out_sum(s5)
    );

    xls_sum_tree_pipe #(.WIDTH(16), .NUM_IN(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2),
        .in_data(d2), .out_valid(ov2), .out_ready(or2), .out_sum(s2)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] exp_wrap;
        logic [31:0] exp_sat;
    } vec_t;

    typedef struct {
        logic [39:0] ops;
        logic [7:0]  exp_wrap;
        logic [7:0]  exp_sat;
    } vec5_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model3(input logic [95:0] d);
        logic [33:0] t;
        t = {2'b00, d[31:0]} + {2'b00, d[63:32]} + {2'b00, d[95:64]};
        if (SAT && t > 34'h0_FFFF_FFFF) return 32'hFFFF_FFFF;
        return t[31:0];
    endfunction

    // One handshake cycle with scoreboard: inputs already driven for this cycle.
    task automatic cycle();
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", {32'd0, out_sum}, 64'hDEAD);
            end else begin
                check("stream_sum", {32'd0, out_sum}, {32'd0, exp_q.pop_front()});
                got_cnt++;
            end
        end
        if (in_valid && in_ready) exp_q.push_back(model3(in_data));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tab[7];
        vec5_t tab5[3];
        logic [31:0] a_sum;
        logic        saw;

        tab[0] = '{32'h1,        32'h2,        32'h3,        32'h6,        32'h6};
        tab[1] = '{32'hFFFFFFFF, 32'h2,        32'h0,        32'h1,        32'hFFFFFFFF};
        tab[2] = '{32'h0,        32'h0,        32'h0,        32'h0,        32'h0};
        tab[3] = '{32'h80000000, 32'h80000000, 32'h5,        32'h5,        32'hFFFFFFFF};
        tab[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF};
        tab[5] = '{32'h12345678, 32'h11111111, 32'h0,        32'h23456789, 32'h23456789};
        tab[6] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h1,        32'hFFFFFFFF, 32'hFFFFFFFF};

        tab5[0] = '{{8'd50, 8'd40, 8'd30, 8'd20, 8'd10}, 8'd150, 8'd150};
        tab5[1] = '{{8'd1, 8'd0, 8'd0, 8'd100, 8'd200}, 8'd45, 8'd255};
        tab5[2] = '{{8'd77, 8'd0, 8'd0, 8'd0, 8'd0},    8'd77, 8'd77};

        // Reset state.
        #3;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_sum", {32'd0, out_sum}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        rst_n = 1'b1;
        step();

        // Default build: latency S=3 and arithmetic table.
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = {tab[i].c, tab[i].b, tab[i].a};
            #1;
            check("vec_in_ready", {63'd0, in_ready}, 64'd1);
            step();
            in_valid = 1'b0;
            step();
            check("vec_early_valid", {63'd0, out_valid}, 64'd0);
            if (i == 0) check("vec_prior_sum", {32'd0, out_sum}, 64'd0);
            step();
            check("vec_valid", {63'd0, out_valid}, 64'd1);
            check("vec_sum", {32'd0, out_sum}, {32'd0, SAT ? tab[i].exp_sat : tab[i].exp_wrap});
            step();
            check("vec_drained", {63'd0, out_valid}, 64'd0);
        end

        // NUM_IN=5, WIDTH=8: S=4, pass-through entries.
        for (int i = 0; i < 3; i++) begin
            v5 = 1'b1;
            d5 = tab5[i].ops;
            step();
            v5 = 1'b0;
            step();
            step();
            check("n5_early_valid", {63'd0, ov5}, 64'd0);
            step();
            check("n5_valid", {63'd0, ov5}, 64'd1);
            check("n5_sum", {56'd0, s5}, {56'd0, SAT ? tab5[i].exp_sat : tab5[i].exp_wrap});
            step();
        end

        // NUM_IN=2: S=2.
        v2 = 1'b1;
        d2 = {16'h0001, 16'h1234};
        step();
        v2 = 1'b0;
        check("n2_early_valid", {63'd0, ov2}, 64'd0);
        step();
        check("n2_valid", {63'd0, ov2}, 64'd1);
        check("n2_sum", {48'd0, s2}, 64'h1235);
        step();

        // Back-to-back streaming, one result per cycle.
        exp_q.delete();
        got_cnt = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom, $urandom};
            cycle();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        check("stream_empty", {32'd0, exp_q.size()}, 64'd0);
        check("stream_count", {32'd0, got_cnt}, 64'd100);

        // Stall: fill the pipe with out_ready low, then drain.
        got_cnt = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = {32'd3 + k, 32'h100 * k, 32'h10 + k};
            if (k == 0) a_sum = model3(in_data);
            #1;
            check("stall_in_ready_fill", {63'd0, in_ready}, 64'd1);
            cycle();
        end
        in_data = {32'h5, 32'h6, 32'h7};
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_in_ready_full", {63'd0, in_ready}, 64'd0);
            check("stall_out_valid", {63'd0, out_valid}, 64'd1);
            check("stall_out_sum", {32'd0, out_sum}, {32'd0, a_sum});
            cycle();
        end
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) cycle();
        check("stall_drain_empty", {32'd0, exp_q.size()}, 64'd0);
        check("stall_drain_count", {32'd0, got_cnt}, 64'd4);

        // Reset with results in flight.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = {32'h11, 32'h22, 32'h33 + k};
            cycle();
        end
        in_valid = 1'b0;
        #1;
        check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_out_sum", {32'd0, out_sum}, 64'd0);
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (out_valid) saw = 1'b1;
        end
        check("post_rst_no_stale", {63'd0, saw}, 64'd0);
        got_cnt = 0;
        in_valid = 1'b1;
        in_data  = {32'd4, 32'd5, 32'd6};
        cycle();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) cycle();
        check("post_rst_count", {32'd0, got_cnt}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
